cond_flag_unit: RTL and testbench
=================================

COND_FLAG_UNIT -- requirements
Module: cond_flag_unit

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk  input  1  single clock, all state updates on posedge
- reset  input  1  asynchronous, active-high
- set_flags  input  1  capture ALU flags this cycle (ADDS/SUBS/ANDS)
- alu_negative  input  1  ALU N flag (result[63])
- alu_zero  input  1  ALU Z flag (NOR of 64-bit result)
- alu_carry  input  1  ALU C flag
- alu_overflow  input  1  ALU V flag
- cond_valid  input  1  condition evaluation request (B.cond)
- cond  input  4  ARM condition code
- flags_q  output  4  stored flags {N,Z,C,V}
- busy  output  1  unit in HOLD; request not accepted
- result_valid  output  1  one-cycle pulse, cond_true is valid
- cond_true  output  1  evaluated condition result

Function
REQ-002 SHALL load flags_q <= {alu_negative,alu_zero,alu_carry,alu_overflow} on posedge clk when set_flags=1, in any state; else hold.
REQ-003 SHALL evaluate cond as: 0000 EQ Z; 0001 NE !Z; 0010 HS C; 0011 LO !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !(C&!Z); 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE !GT; 1110 AL 1; 1111 NV 1.
REQ-004 SHALL implement a two-state FSM: IDLE, HOLD.
REQ-005 IDLE, cond_valid=1, set_flags=0: SHALL evaluate on flags_q, register cond_true, pulse result_valid next cycle (latency 1); stay IDLE.
REQ-006 IDLE, cond_valid=1, set_flags=1 (hazard): behaviour per REQ-014/REQ-015.
REQ-007 HOLD: SHALL evaluate latched cond on flags_q (already updated), pulse result_valid next cycle, return to IDLE.
REQ-008 busy SHALL be 1 exactly while state=HOLD; cond_valid in HOLD SHALL be ignored (no latch, no result).
REQ-009 result_valid SHALL be a single-cycle pulse per accepted request; cond_true SHALL hold its last value when result_valid=0.
REQ-010 set_flags in HOLD SHALL update flags_q but SHALL NOT affect the pending evaluation (uses flags captured on HOLD entry edge).
REQ-011 cond_valid=0 SHALL never produce result_valid, regardless of set_flags.

Reset
REQ-012 reset=1 SHALL asynchronously force: state=IDLE, flags_q=4'b0000, busy=0, result_valid=0, cond_true=0, latched cond=0.
REQ-013 reset asserted in HOLD SHALL discard the pending request; no result_valid after reset release.

Configuration
REQ-014 Macro COND_FLAG_FORWARD_EN defined: hazard case SHALL evaluate on incoming ALU flags (forwarded), latency 1, no HOLD entry, busy stays 0.
REQ-015 Macro COND_FLAG_FORWARD_EN undefined: hazard case SHALL latch cond, enter HOLD (busy=1 next cycle), result_valid two cycles after request.
REQ-016 flags_q update behaviour SHALL be identical in both builds.

Verification
REQ-017 reset, then cond_valid=1 cond=0000 -> next cycle result_valid=1, cond_true=1 (Z=0 after reset? no: flags 0000, EQ false) -> cond_true=0; cond=0001 -> cond_true=1.
REQ-018 set_flags=1 with N=1,V=0 ({1,0,0,0}), next cycle cond=1011 (LT) -> flags_q=4'b1000, cond_true=1; cond=1010 (GE) -> cond_true=0.
REQ-019 same-cycle set_flags=1 Z=1 and cond_valid=1 cond=0000: forward build -> result_valid next cycle, cond_true=1, busy=0; non-forward -> busy=1 one cycle, result_valid at cycle+2, cond_true=1.
REQ-020 non-forward: in HOLD drive cond_valid=1 cond=0001 and set_flags Z=0 -> only one result_valid, cond_true=1 (EQ on Z=1), flags_q Z=0 afterwards.
REQ-021 non-forward: assert reset during HOLD -> flags_q=0000, busy=0, no result_valid after release.
REQ-022 sweep all 16 cond codes over all 16 flag values -> cond_true matches REQ-003 table, 256 checks, 1-cycle latency.

Source files
------------

// File: rtl/cond_flag_unit.sv
// ---------------------------------------------------------------------------
// cond_flag_unit
//
// Holds the ARM-style NZCV condition flags and evaluates 4-bit condition
// codes against them for conditional branches (B.cond).
//
// Build option:
//   COND_FLAG_FORWARD_EN  - when defined, a request that arrives in the same
//                           cycle as a flag update is evaluated on the incoming
//                           ALU flags (forwarded) with 1-cycle latency. When
//                           undefined, the request is parked for one cycle in
//                           HOLD and evaluated on the freshly stored flags
//                           (2-cycle latency, busy asserted during HOLD).
//
// Ports:
//   clk           in   clock, all state updates on posedge
//   reset         in   asynchronous, active-high reset
//   set_flags     in   capture ALU flags this cycle
//   alu_negative  in   ALU N flag
//   alu_zero      in   ALU Z flag
//   alu_carry     in   ALU C flag
//   alu_overflow  in   ALU V flag
//   cond_valid    in   condition evaluation request
//   cond          in   [3:0] condition code
//   flags_q       out  [3:0] stored flags {N,Z,C,V}
//   busy          out  unit in HOLD, requests ignored
//   result_valid  out  one-cycle pulse, cond_true valid
//   cond_true     out  evaluated condition result (holds between pulses)
// ---------------------------------------------------------------------------
module cond_flag_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_flags,
    input  logic       alu_negative,
    input  logic       alu_zero,
    input  logic       alu_carry,
    input  logic       alu_overflow,
    input  logic       cond_valid,
    input  logic [3:0] cond,
    output logic [3:0] flags_q,
    output logic       busy,
    output logic       result_valid,
    output logic       cond_true
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] cond_reg;

    logic [3:0] alu_flags;
    logic       fire;        // produce a result at the next edge
    logic       latch_en;    // park the request for HOLD
    logic [3:0] eval_cond;
    logic [3:0] eval_flags;
    logic       eval_result;

    assign alu_flags = {alu_negative, alu_zero, alu_carry, alu_overflow};

    // Condition codes come in complementary pairs: bit 0 inverts the base
    // test selected by bits [3:1]. The only exception is 1111 (NV), which
    // behaves like AL and is always true.
    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c[3:1])
            3'b000:  base = z;
            3'b001:  base = cy;
            3'b010:  base = n;
            3'b011:  base = v;
            3'b100:  base = cy & ~z;
            3'b101:  base = (n == v);
            3'b110:  base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (c[0] && (c[3:1] != 3'b111)) begin
            return ~base;
        end
        return base;
    endfunction

    // Next-state and evaluation-source selection
    always_comb begin
        state_next = state_reg;
        fire       = 1'b0;
        latch_en   = 1'b0;
        eval_cond  = cond;
        eval_flags = flags_q;
        case (state_reg)
            IDLE: begin
                if (cond_valid) begin
                    if (set_flags) begin
`ifdef COND_FLAG_FORWARD_EN
                        fire       = 1'b1;
                        eval_flags = alu_flags;
`else
                        latch_en   = 1'b1;
                        state_next = HOLD;
`endif
                    end else begin
                        fire = 1'b1;
                    end
                end
            end
            HOLD: begin
                // flags_q still holds the value captured on the HOLD entry
                // edge; a set_flags now only lands at the end of this cycle.
                fire       = 1'b1;
                eval_cond  = cond_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign eval_result = cond_eval(eval_cond, eval_flags);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            cond_reg     <= 4'b0000;
            flags_q      <= 4'b0000;
            result_valid <= 1'b0;
            cond_true    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            result_valid <= fire;
            if (set_flags) begin
                flags_q <= alu_flags;
            end
            if (latch_en) begin
                cond_reg <= cond;
            end
            if (fire) begin
                cond_true <= eval_result;
            end
        end
    end

    assign busy = (state_reg == HOLD);

endmodule

// File: tb/tb_cond_flag_unit.sv
// ---------------------------------------------------------------------------
// tb_cond_flag_unit
//
// Directed bench for cond_flag_unit. A scoreboard model predicts, per
// accepted request, the cycle its result must appear and its value; a
// compare process checks every output on each falling edge. Literal
// expectations for the documented scenarios pin the model.
// Honours COND_FLAG_FORWARD_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_cond_flag_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       set_flags = 1'b0;
    logic       alu_negative = 1'b0;
    logic       alu_zero = 1'b0;
    logic       alu_carry = 1'b0;
    logic       alu_overflow = 1'b0;
    logic       cond_valid = 1'b0;
    logic [3:0] cond = 4'b0000;
    logic [3:0] flags_q;
    logic       busy;
    logic       result_valid;
    logic       cond_true;

    int checks = 0;
    int errors = 0;

    cond_flag_unit dut (
        .clk          (clk),
        .reset        (reset),
        .set_flags    (set_flags),
        .alu_negative (alu_negative),
        .alu_zero     (alu_zero),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .cond_valid   (cond_valid),
        .cond         (cond),
        .flags_q      (flags_q),
        .busy         (busy),
        .result_valid (result_valid),
        .cond_true    (cond_true)
    );

    always #5 clk = ~clk;

    // Reference truth table, straight from the condition-code list
    function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !(cy && !z);
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return !(!z && (n == v));
            default: return 1'b1;
        endcase
    endfunction

    // ---------------- scoreboard model ----------------
    typedef struct {
        int due;
        bit val;
    } res_t;

    res_t       pend[$];
    int         cyc = 0;
    int         hold_cycle = -10;  // cycle during which busy must be high
    logic [3:0] m_flags = 4'b0000;
    bit         exp_rv = 1'b0;
    bit         exp_ct = 1'b0;
    bit         exp_busy = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend.delete();
            hold_cycle = -10;
            m_flags    = 4'b0000;
            exp_rv     = 1'b0;
            exp_ct     = 1'b0;
            exp_busy   = 1'b0;
        end else begin
            logic [3:0] inflags;
            bit         was_busy;
            inflags  = {alu_negative, alu_zero, alu_carry, alu_overflow};
            was_busy = (hold_cycle == cyc);
            cyc      = cyc + 1;
            if (cond_valid && !was_busy) begin
                if (set_flags) begin
`ifdef COND_FLAG_FORWARD_EN
                    pend.push_back('{due: cyc, val: ref_cond(cond, inflags)});
`else
                    pend.push_back('{due: cyc + 1, val: ref_cond(cond, inflags)});
                    hold_cycle = cyc;
`endif
                end else begin
                    pend.push_back('{due: cyc, val: ref_cond(cond, m_flags)});
                end
            end
            if (set_flags) m_flags = inflags;
            exp_busy = (hold_cycle == cyc);
            exp_rv   = 1'b0;
            while (pend.size() > 0 && pend[0].due < cyc) pend.pop_front();
            if (pend.size() > 0 && pend[0].due == cyc) begin
                exp_rv = 1'b1;
                exp_ct = pend[0].val;
                pend.pop_front();
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        checks = checks + 4;
        if (flags_q !== m_flags) begin
            errors = errors + 1;
            $display("FAIL cyc%0d flags_q: got %b expected %b", cyc, flags_q, m_flags);
        end
        if (busy !== exp_busy) begin
            errors = errors + 1;
            $display("FAIL cyc%0d busy: got %b expected %b", cyc, busy, exp_busy);
        end
        if (result_valid !== exp_rv) begin
            errors = errors + 1;
            $display("FAIL cyc%0d result_valid: got %b expected %b", cyc, result_valid, exp_rv);
        end
        if (cond_true !== exp_ct) begin
            errors = errors + 1;
            $display("FAIL cyc%0d cond_true: got %b expected %b", cyc, cond_true, exp_ct);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic lit(input string name, input logic [3:0] got, input logic [3:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s: got %b expected %b", name, got, want);
        end
    endtask

    // Present one cycle of inputs across a rising edge, then return them idle.
    task automatic step(input bit sf, input logic [3:0] f, input bit cv, input logic [3:0] c);
        set_flags = sf;
        {alu_negative, alu_zero, alu_carry, alu_overflow} = f;
        cond_valid = cv;
        cond = c;
        @(posedge clk);
        #1;
        set_flags = 1'b0;
        cond_valid = 1'b0;
        $display("txn t=%0t sf=%b f=%b cv=%b cond=%b -> flags_q=%b busy=%b rv=%b ct=%b",
                 $time, sf, f, cv, c, flags_q, busy, result_valid, cond_true);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        lit("reset_flags", flags_q, 4'b0000);
        lit("reset_outs", {1'b0, busy, result_valid, cond_true}, 4'b0000);
        reset = 1'b0;

        // EQ / NE on cleared flags
        step(0, 4'b0000, 1, 4'b0000);
        lit("eq_after_reset", {2'b00, result_valid, cond_true}, 4'b0010);
        step(0, 4'b0000, 1, 4'b0001);
        lit("ne_after_reset", {2'b00, result_valid, cond_true}, 4'b0011);

        // LT / GE with N=1, V=0
        step(1, 4'b1000, 0, 4'b0000);
        lit("flags_n_set", flags_q, 4'b1000);
        lit("no_rv_without_req", {3'b000, result_valid}, 4'b0000);
        step(0, 4'b0000, 1, 4'b1011);
        lit("lt_true", {2'b00, result_valid, cond_true}, 4'b0011);
        step(0, 4'b0000, 1, 4'b1010);
        lit("ge_false", {2'b00, result_valid, cond_true}, 4'b0010);

        // Hazard: set Z=1 together with EQ request, then a request in HOLD
        step(1, 4'b0100, 1, 4'b0000);
`ifdef COND_FLAG_FORWARD_EN
        lit("hazard_fwd", {1'b0, busy, result_valid, cond_true}, 4'b0011);
        step(1, 4'b0000, 1, 4'b0001);
        lit("hazard_fwd_ne", {1'b0, busy, result_valid, cond_true}, 4'b0011);
`else
        lit("hazard_hold", {1'b0, busy, result_valid, cond_true}, 4'b0100);
        step(1, 4'b0000, 1, 4'b0001);
        lit("hazard_result", {1'b0, busy, result_valid, cond_true}, 4'b0011);
`endif
        lit("flags_after_hold", flags_q, 4'b0000);
        step(0, 4'b0000, 0, 4'b0000);
        lit("single_pulse", {1'b0, busy, result_valid, 1'b0}, 4'b0000);

        // Reset while a request is parked
        step(1, 4'b1111, 1, 4'b0000);
`ifndef COND_FLAG_FORWARD_EN
        lit("hold_before_reset", {3'b000, busy}, 4'b0001);
`endif
        #2 reset = 1'b1;
        #1;
        lit("async_reset_flags", flags_q, 4'b0000);
        lit("async_reset_outs", {1'b0, busy, result_valid, cond_true}, 4'b0000);
        @(posedge clk);
        #1 reset = 1'b0;
        step(0, 4'b0000, 0, 4'b0000);
        lit("no_rv_after_reset", {2'b00, busy, result_valid}, 4'b0000);
        step(0, 4'b0000, 0, 4'b0000);
        lit("no_rv_after_reset2", {2'b00, busy, result_valid}, 4'b0000);

        // Full sweep: every condition code against every flag combination
        for (int f = 0; f < 16; f++) begin
            step(1, 4'(f), 0, 4'b0000);
            for (int c = 0; c < 16; c++) begin
                step(0, 4'b0000, 1, 4'(c));
            end
        end
        step(0, 4'b0000, 0, 4'b0000);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
